// File: rtl/angle_frame_tx.sv
// Attitude frame transmitter: scales pitch/yaw to centidegrees and streams an
// 8-byte frame (header, id, angles, checksum) into a UART TX byte engine.
module angle_frame_tx #(
    parameter logic [7:0]  HDR0       = 8'hA5,
    parameter logic [7:0]  HDR1       = 8'h5A,
    parameter logic [7:0]  FRAME_ID   = 8'h53,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [7:0] pitch_deg,
    input  logic [7:0] yaw_deg,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 32'd0) ? 16'd0 : 16'(GAP_CYCLES - 32'd1);

    // x*100 as shift-and-add on the sign-extended angle; range fits 16 bits
    function automatic logic [15:0] scale100(input logic [7:0] deg);
        logic [15:0] x;
        x = {{8{deg[7]}}, deg};
        return (x << 4'd6) + (x << 4'd5) + (x << 4'd2);
    endfunction

    function automatic logic [7:0] frame_sum(input logic [15:0] p, input logic [15:0] y);
        return HDR0 + HDR1 + FRAME_ID + p[15:8] + p[7:0] + y[15:8] + y[7:0];
    endfunction

    state_t      state_r;
    logic [2:0]  idx_r;
    logic [7:0]  pitch_r;
    logic [7:0]  yaw_r;
    logic [15:0] p_r;
    logic [15:0] y_r;
    logic [7:0]  chk_r;
    logic [15:0] gap_cnt_r;

    logic [15:0] p_s;
    logic [15:0] y_s;
    logic [7:0]  chk_s;
    logic [2:0]  next_idx_s;
    logic [7:0]  next_byte_s;

    // Scaled angles and checksum derived from the request snapshot
    always_comb begin
        p_s   = scale100(pitch_r);
        y_s   = scale100(yaw_r);
        chk_s = frame_sum(p_s, y_s);
    end

    // Byte that follows the one currently held on tx_data
    always_comb begin
        next_idx_s = idx_r + 3'd1;
        case (next_idx_s)
            3'd0:    next_byte_s = HDR0;
            3'd1:    next_byte_s = HDR1;
            3'd2:    next_byte_s = FRAME_ID;
            3'd3:    next_byte_s = p_r[15:8];
            3'd4:    next_byte_s = p_r[7:0];
            3'd5:    next_byte_s = y_r[15:8];
            3'd6:    next_byte_s = y_r[7:0];
            3'd7:    next_byte_s = chk_r;
            default: next_byte_s = 8'h00;
        endcase
    end

    // Load strobe: issued straight from ARM so byte 0 leaves two cycles after accept
    always_comb begin
        if ((state_r == S_ARM) && !tx_busy) begin
            tx_start = 1'b1;
        end else begin
            tx_start = 1'b0;
        end
    end

    // Frame sequencer with registered data, busy and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            idx_r      <= 3'd0;
            pitch_r    <= 8'd0;
            yaw_r      <= 8'd0;
            p_r        <= 16'd0;
            y_r        <= 16'd0;
            chk_r      <= 8'd0;
            gap_cnt_r  <= 16'd0;
            tx_data    <= 8'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (send_req) begin
                        pitch_r <= pitch_deg;
                        yaw_r   <= yaw_deg;
                        busy    <= 1'b1;
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    p_r     <= p_s;
                    y_r     <= y_s;
                    chk_r   <= chk_s;
                    idx_r   <= 3'd0;
                    tx_data <= HDR0;
                    state_r <= S_ARM;
                end
                S_ARM: begin
                    if (!tx_busy) begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (idx_r != 3'd7) begin
                            idx_r   <= next_idx_s;
                            tx_data <= next_byte_s;
                            state_r <= S_ARM;
                        end else begin
                            frame_done <= 1'b1;
                            gap_cnt_r  <= 16'd0;
                            if (GAP_CYCLES == 32'd0) begin
                                busy    <= 1'b0;
                                state_r <= S_IDLE;
                            end else begin
                                state_r <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 16'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_angle_frame_tx.sv
// Directed bench for angle_frame_tx with a small ideal UART TX model.
module tb_angle_frame_tx;

    logic       clk;
    logic       rst;
    logic       send_req;
    logic [7:0] pitch_deg;
    logic [7:0] yaw_deg;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       frame_done;

    logic       uart_busy;
    logic       busy_force;
    logic [2:0] ub_cnt;
    logic       prev_start;
    logic [7:0] cap [0:127];
    int         cap_n;
    int         dbl_start;
    int         stab_err;
    int         fd_cnt;

    int checks;
    int errors;
    int base;
    int gap_n;
    int fd0;
    bit saw_start;

    assign tx_busy = uart_busy | busy_force;

    angle_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .send_req   (send_req),
        .pitch_deg  (pitch_deg),
        .yaw_deg    (yaw_deg),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal UART: accepts a byte on tx_start, busy 4 cycles, then one tx_done pulse
    always @(posedge clk) begin
        tx_done    <= 1'b0;
        prev_start <= tx_start;
        if (tx_start && prev_start) dbl_start <= dbl_start + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (tx_done && cap_n > 0 && tx_data !== cap[cap_n-1]) stab_err <= stab_err + 1;
        if (uart_busy) begin
            if (ub_cnt == 3'd0) begin
                uart_busy <= 1'b0;
                tx_done   <= 1'b1;
            end else begin
                ub_cnt <= ub_cnt - 3'd1;
            end
        end else if (tx_start) begin
            uart_busy  <= 1'b1;
            ub_cnt     <= 3'd3;
            cap[cap_n] <= tx_data;
            cap_n      <= cap_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: request held for one cycle, returns at the next negedge
    task automatic send(input logic [7:0] p, input logic [7:0] y);
        send_req  = 1'b1;
        pitch_deg = p;
        yaw_deg   = y;
        @(negedge clk);
        send_req  = 1'b0;
        pitch_deg = 8'h3C;
        yaw_deg   = 8'hC3;
    endtask

    // Waits for frame_done, then counts cycles until busy drops (optionally poking send_req in GAP)
    task automatic wait_frame(input bit poke_gap, output int gn);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        gn   = 0;
        while (!seen && n < 800) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        chk("frame_done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            while (busy === 1'b1 && gn < 200) begin
                @(negedge clk);
                gn++;
                if (poke_gap) begin
                    send_req  = (gn == 3);
                    pitch_deg = 8'h01;
                    yaw_deg   = 8'h01;
                end
            end
            send_req = 1'b0;
        end
    endtask

    task automatic cmp_frame(input int b, input logic [63:0] e, input string nm);
        logic [7:0] eb;
        for (int i = 0; i < 8; i++) begin
            eb = e[63-8*i -: 8];
            chk($sformatf("%s_b%0d", nm, i), {24'd0, cap[b+i]}, {24'd0, eb});
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cap_n      = 0;
        dbl_start  = 0;
        stab_err   = 0;
        fd_cnt     = 0;
        uart_busy  = 1'b0;
        ub_cnt     = 3'd0;
        tx_done    = 1'b0;
        prev_start = 1'b0;
        busy_force = 1'b0;
        send_req   = 1'b0;
        pitch_deg  = 8'h00;
        yaw_deg    = 8'h00;
        rst        = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {31'd0, tx_start}, 32'd0);

        // Frame 1: +12 / -5, latency and gap length
        base = cap_n;
        fd0  = fd_cnt;
        send(8'h0C, 8'hFB);
        chk("f1_busy_after_accept", {31'd0, busy}, 32'd1);
        chk("f1_no_start_n1", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        chk("f1_start_n2", {31'd0, tx_start}, 32'd1);
        chk("f1_data_n2", {24'd0, tx_data}, 32'hA5);
        wait_frame(1'b0, gap_n);
        chk("f1_gap_len", gap_n, 32'd16);
        chk("f1_fd_once", fd_cnt - fd0, 32'd1);
        cmp_frame(base, 64'hA55A5304B0FE0C10, "f1");

        // Frame 2: extremes, requests mid-frame and during GAP are ignored
        base = cap_n;
        send(8'h80, 8'h7F);
        repeat (15) @(negedge clk);
        send(8'h01, 8'h01);
        wait_frame(1'b1, gap_n);
        chk("f2_gap_len", gap_n, 32'd16);
        chk("f2_no_extra_bytes", cap_n - base, 32'd8);
        cmp_frame(base, 64'hA55A53CE00319CED, "f2");

        // Frame 3: zero angles, accepted in the first IDLE cycle after GAP
        base = cap_n;
        send(8'h00, 8'h00);
        chk("f3_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("f3_start_n2", {31'd0, tx_start}, 32'd1);
        wait_frame(1'b0, gap_n);
        cmp_frame(base, 64'hA55A530000000052, "f3");

        // Frame 4: tx_busy held high in ARM delays the first start
        base       = cap_n;
        busy_force = 1'b1;
        send(8'h0C, 8'hFB);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("f4_hold_start_%0d", i), {31'd0, tx_start}, 32'd0);
            chk($sformatf("f4_hold_data_%0d", i), {24'd0, tx_data}, 32'hA5);
            @(negedge clk);
        end
        busy_force = 1'b0;
        #1;
        chk("f4_release_start", {31'd0, tx_start}, 32'd1);
        chk("f4_release_data", {24'd0, tx_data}, 32'hA5);
        @(negedge clk);
        chk("f4_single_pulse", {31'd0, tx_start}, 32'd0);
        wait_frame(1'b0, gap_n);
        cmp_frame(base, 64'hA55A5304B0FE0C10, "f4");

        // Frame 5: reset while byte 4 is in flight
        base = cap_n;
        send(8'h80, 8'h7F);
        for (int n = 0; n < 400 && cap_n < base + 5; n++) @(negedge clk);
        chk("f5_reached_byte4", cap_n - base, 32'd5);
        rst = 1'b1;
        #1;
        chk("f5_rst_tx_data", {24'd0, tx_data}, 32'h0);
        chk("f5_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("f5_rst_busy", {31'd0, busy}, 32'd0);
        chk("f5_rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        saw_start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tx_start === 1'b1) saw_start = 1'b1;
        end
        chk("f5_no_start_after_rst", {31'd0, saw_start}, 32'd0);
        chk("f5_no_bytes_after_rst", cap_n - base, 32'd5);

        // Frame 6: clean frame after the aborted one
        base = cap_n;
        send(8'h0C, 8'hFB);
        wait_frame(1'b0, gap_n);
        cmp_frame(base, 64'hA55A5304B0FE0C10, "f6");

        chk("no_back_to_back_start", dbl_start, 32'd0);
        chk("tx_data_stable", stab_err, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
